// File: rtl/hex_display_bank.sv
// Value register, nibble decode, blink timer and leading-zero blanking
// driving a bank of active-low 7-segment digits.
module hex_display_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_din,
    input  logic                    i_inc,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    input  logic                    i_lzb_en,
    output logic [4*NUM_DIGITS-1:0] o_value_q,
    output logic [7*NUM_DIGITS-1:0] o_hex
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int HW = 7 * NUM_DIGITS;
    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    logic [VW-1:0]         r_value;
    logic [CW-1:0]         r_cnt;
    logic                  r_phase;
    logic [HW-1:0]         r_hex;
    logic [NUM_DIGITS-1:0] w_allz;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [HW-1:0]         w_hex;

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // w_allz[i]: every nibble from digit i up to the top digit is zero
    always_comb begin
        w_allz  = '0;
        w_blank = '0;
        w_hex   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_allz[i]  = ((r_value >> (4 * i)) == VW'(0));
            w_blank[i] = (i_blink_mask[i] && r_phase)
                       || (i_lzb_en && (i > 0) && w_allz[i]);
            w_hex[7*i +: 7] = w_blank[i] ? 7'h7F : seg(r_value[4*i +: 4]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_value <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_hex   <= '1;
        end else begin
            if (i_load) begin
                r_value <= i_din;
            end else if (i_inc) begin
                r_value <= r_value + VW'(1);
            end
            if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_hex <= w_hex;
        end
    end

    assign o_value_q = r_value;
    assign o_hex     = r_hex;

endmodule
